// File: rtl/snake_pkg.sv
// Shared screen geometry, pixel format and block-reader state encoding.
package snake_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BLOCK    = 10;
  localparam int COL_W    = 4;

  // Framebuffer value treated as "empty" when searching a block.
  localparam int BLACK    = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/block_reader.sv
// Scans a BLOCKxBLOCK framebuffer window column-major and reports the first non-black pixel.
// done pulses BLOCK*BLOCK+2 cycles after start is accepted; no backpressure, start is dropped while busy.
module block_reader #(
  parameter int BLOCK    = snake_pkg::BLOCK,
  parameter int SCREEN_W = snake_pkg::SCREEN_W,
  parameter int SCREEN_H = snake_pkg::SCREEN_H,
  parameter int COL_W    = snake_pkg::COL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       x_in,
  input  logic [6:0]       y_in,
  output logic             rd_en,
  output logic [7:0]       rd_x,
  output logic [6:0]       rd_y,
  input  logic [COL_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [COL_W-1:0] hit_colour
);
  import snake_pkg::*;

  localparam int               CNT_W   = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [7:0]       x_base_q, x_base_d;
  logic [6:0]       y_base_q, y_base_d;
  logic             rd_en_q, rd_en_d;
  logic [7:0]       rd_x_q, rd_x_d;
  logic [6:0]       rd_y_q, rd_y_d;
  logic             last_q, last_d;
  logic             vld_q;
  logic             hit_q, hit_d;
  logic [COL_W-1:0] colour_q, colour_d;

  logic [8:0]       sum_x;
  logic [7:0]       sum_y;
  logic             in_screen;
  logic             issue;

  // One bit of headroom so a window hanging off the right/bottom edge clips instead of wrapping.
  always_comb begin
    sum_x     = {1'b0, x_base_q} + 9'(col_q);
    sum_y     = {1'b0, y_base_q} + 8'(row_q);
    in_screen = (int'(sum_x) < SCREEN_W) && (int'(sum_y) < SCREEN_H);
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    x_base_d = x_base_q;
    y_base_d = y_base_q;
    rd_en_d  = 1'b0;
    rd_x_d   = rd_x_q;
    rd_y_d   = rd_y_q;
    last_d   = 1'b0;
    hit_d    = hit_q;
    colour_d = colour_q;
    issue    = 1'b0;

    if (vld_q && (rd_data != COL_W'(BLACK)) && !hit_q) begin
      hit_d    = 1'b1;
      colour_d = rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SCAN;
          x_base_d = x_in;
          y_base_d = y_in;
          col_d    = '0;
          row_d    = '0;
          hit_d    = 1'b0;
          colour_d = '0;
        end
      end
      ST_SCAN: begin
        // last_q marks that the final read is on the bus this cycle; stop issuing.
        if (last_q) begin
          state_d = ST_DRAIN;
        end else begin
          issue  = 1'b1;
          last_d = (col_q == CNT_MAX) && (row_q == CNT_MAX);
          if (row_q == CNT_MAX) begin
            row_d = '0;
            col_d = (col_q == CNT_MAX) ? '0 : col_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_DRAIN:  state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (issue && in_screen) begin
      rd_en_d = 1'b1;
      rd_x_d  = sum_x[7:0];
      rd_y_d  = sum_y[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      x_base_q <= '0;
      y_base_q <= '0;
      rd_en_q  <= 1'b0;
      rd_x_q   <= '0;
      rd_y_q   <= '0;
      last_q   <= 1'b0;
      vld_q    <= 1'b0;
      hit_q    <= 1'b0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_base_q <= x_base_d;
      y_base_q <= y_base_d;
      rd_en_q  <= rd_en_d;
      rd_x_q   <= rd_x_d;
      rd_y_q   <= rd_y_d;
      last_q   <= last_d;
      vld_q    <= rd_en_q;
      hit_q    <= hit_d;
      colour_q <= colour_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_REPORT);
  assign hit        = hit_q;
  assign hit_colour = colour_q;

endmodule

// File: tb/tb_block_reader.sv
// Randomised scoreboard bench for block_reader against a framebuffer array model.
module tb_block_reader;

  typedef struct { int x; int y; } rd_t;
  typedef struct { bit h; int col; int cyc; } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic       rd_en;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [3:0] rd_data;
  logic       busy, done, hit;
  logic [3:0] hit_colour;

  logic [3:0] mem [160][120];
  rd_t        exp_rd[$];
  res_t       exp_res[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         last_x = 0, last_y = 0;
  bit         exp_hit;
  int         exp_col;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  block_reader dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .busy(busy), .done(done), .hit(hit), .hit_colour(hit_colour)
  );

  // Framebuffer: data one cycle after the strobe, random junk otherwise.
  always @(posedge clk) begin
    if (rd_en && rd_x < 8'd160 && rd_y < 7'd120) rd_data <= mem[rd_x][rd_y];
    else rd_data <= 4'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: visit every in-screen pixel of the window column by column.
  task automatic push_job(input int x, input int y, input int k, output bit h, output int col);
    h = 0;
    col = 0;
    for (int c = 0; c < 10; c++) begin
      for (int r = 0; r < 10; r++) begin
        int px, py;
        px = x + c;
        py = y + r;
        if (px < 160 && py < 120) begin
          exp_rd.push_back('{px, py});
          if (!h && mem[px][py] != 0) begin
            h = 1;
            col = int'(mem[px][py]);
          end
        end
      end
    end
    exp_res.push_back('{h, col, k + 102});
  endtask

  always @(negedge clk) begin
    rd_t  e;
    res_t r;
    if (rd_en) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", rd_en, 0);
      else begin
        e = exp_rd.pop_front();
        chk("rd_x", rd_x, e.x);
        chk("rd_y", rd_y, e.y);
        last_x = e.x;
        last_y = e.y;
      end
    end else begin
      chk("rd_x_hold", rd_x, last_x);
      chk("rd_y_hold", rd_y, last_y);
    end
    if (done) begin
      if (exp_res.size() == 0) chk("done_unexpected", done, 0);
      else begin
        r = exp_res.pop_front();
        chk("done_cycle", cyc, r.cyc);
        chk("hit", hit, r.h);
        chk("hit_colour", hit_colour, r.col);
      end
    end
  end

  task automatic clear_mem();
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) mem[x][y] = 4'h0;
  endtask

  task automatic rand_mem();
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        mem[x][y] = ($urandom_range(0, 40) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
  endtask

  task automatic start_job(input int x, input int y, output int k);
    bit h;
    int col;
    @(negedge clk);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    x_in  = 8'(x);
    y_in  = 7'(y);
    start = 1'b1;
    k     = cyc + 1;
    push_job(x, y, k, h, col);
    exp_hit = h;
    exp_col = col;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_on_accept", busy, 1);
    chk("hit_cleared", hit, 0);
    chk("colour_cleared", hit_colour, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && exp_res.size() != 0; i++) @(negedge clk);
    chk("done_timeout", exp_res.size(), 0);
    @(negedge clk);
    chk("hit_held", hit, exp_hit);
    chk("colour_held", hit_colour, exp_col);
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_x"}, rd_x, 0);
    chk({tag, "_rd_y"}, rd_y, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_colour"}, hit_colour, 0);
  endtask

  initial begin
    int  k, d;
    bit  h;
    int  col;
    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");

    // All black, then single pixel, then two pixels in different columns.
    start_job(20, 30, k); wait_idle();
    mem[25][33] = 4'h3;
    start_job(20, 30, k); wait_idle();
    clear_mem();
    mem[22][31] = 4'h5;
    mem[27][30] = 4'h9;
    start_job(20, 30, k); wait_idle();

    // Bottom-right corner clipping.
    mem[157][116] = 4'h2;
    start_job(155, 115, k); wait_idle();

    // Start pulse mid-scan must be dropped.
    start_job(20, 30, k);
    while (cyc < k + 50) @(negedge clk);
    x_in  = 8'd0;
    y_in  = 7'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Reset mid-scan after a hit has been captured.
    mem[20][31] = 4'h6;
    start_job(20, 30, k);
    while (cyc < k + 40) @(negedge clk);
    chk("pre_reset_hit", hit, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_rd.delete();
    exp_res.delete();
    last_x = 0;
    last_y = 0;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midscan_reset");
    repeat (120) @(negedge clk);
    start_job(20, 30, k); wait_idle();

    // start held across REPORT: ignored there, accepted in the following idle cycle.
    start_job(40, 50, k);
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    d = cyc;
    mem[61][52] = 4'hc;
    x_in  = 8'd60;
    y_in  = 7'd50;
    start = 1'b1;
    push_job(60, 50, d + 2, h, col);
    exp_hit = h;
    exp_col = col;
    @(posedge clk);
    #1;
    chk("report_start_ignored", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("idle_start_taken", busy, 1);
    chk("b2b_hit_cleared", hit, 0);
    wait_idle();

    // Random windows over random sparse framebuffers.
    repeat (10) begin
      int rx, ry;
      rand_mem();
      rx = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 150);
      ry = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 110);
      start_job(rx, ry, k);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("rd_leftover", exp_rd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
